// File: rtl/image_pkg.sv
// Shared types and constants for the image stream source: FSM states, pattern
// encodings, bar colours and pixel helpers.
package image_pkg;

  localparam int PIX_W = 24;

  typedef logic [PIX_W-1:0] rgb_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_VBLANK = 2'd1,
    ST_ACTIVE = 2'd2,
    ST_HBLANK = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    PAT_BARS    = 2'd0,
    PAT_RAMP    = 2'd1,
    PAT_CHECKER = 2'd2,
    PAT_XOR     = 2'd3
  } pattern_t;

  localparam rgb_t RGB_WHITE   = 24'hFF_FF_FF;
  localparam rgb_t RGB_YELLOW  = 24'hFF_FF_00;
  localparam rgb_t RGB_CYAN    = 24'h00_FF_FF;
  localparam rgb_t RGB_GREEN   = 24'h00_FF_00;
  localparam rgb_t RGB_MAGENTA = 24'hFF_00_FF;
  localparam rgb_t RGB_RED     = 24'hFF_00_00;
  localparam rgb_t RGB_BLUE    = 24'h00_00_FF;
  localparam rgb_t RGB_BLACK   = 24'h00_00_00;

  function automatic rgb_t gray(input logic [7:0] g);
    return {g, g, g};
  endfunction

  function automatic rgb_t bar_colour(input logic [2:0] idx);
    case (idx)
      3'd0:    return RGB_WHITE;
      3'd1:    return RGB_YELLOW;
      3'd2:    return RGB_CYAN;
      3'd3:    return RGB_GREEN;
      3'd4:    return RGB_MAGENTA;
      3'd5:    return RGB_RED;
      3'd6:    return RGB_BLUE;
      default: return RGB_BLACK;
    endcase
  endfunction

endpackage

// File: rtl/image_stream_source_if.sv
// Frame-source bundle: configuration inputs plus the pixel stream and sync side signals.
interface image_stream_source_if;
  import image_pkg::*;

  logic        enable;
  logic [10:0] img_width;
  logic [9:0]  img_height;
  logic [1:0]  pattern_sel;

  logic        frame_clk_o;
  logic        frame_ce_o;
  logic        valid_o;
  rgb_t        img_data_o;
  logic        sof_o;
  logic        eol_o;

  modport master (
    input  enable, img_width, img_height, pattern_sel,
    output frame_clk_o, frame_ce_o, valid_o, img_data_o, sof_o, eol_o
  );

  modport slave (
    output enable, img_width, img_height, pattern_sel,
    input  frame_clk_o, frame_ce_o, valid_o, img_data_o, sof_o, eol_o
  );

endinterface

// File: rtl/image_pattern_lut.sv
// Registered test-pattern generator: maps pixel coordinates and bar index to RGB,
// one cycle of latency, black whenever the line is not active.
module image_pattern_lut
  import image_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       i_active,
  input  logic [7:0] i_x,
  input  logic [7:0] i_y,
  input  logic [2:0] i_bar_idx,
  input  pattern_t   i_pattern,
  output rgb_t       o_rgb
);

  rgb_t w_rgb;
  rgb_t r_rgb;

  always_comb begin
    w_rgb = '0;
    if (i_active) begin
      case (i_pattern)
        PAT_BARS:    w_rgb = bar_colour(i_bar_idx);
        PAT_RAMP:    w_rgb = gray(i_x);
        PAT_CHECKER: w_rgb = (i_x[3] ^ i_y[3]) ? gray(8'hFF) : gray(8'h00);
        PAT_XOR:     w_rgb = gray(i_x ^ i_y);
        default:     w_rgb = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_rgb <= '0;
    else          r_rgb <= w_rgb;
  end

  assign o_rgb = r_rgb;

endmodule

// File: rtl/image_stream_source.sv
// Free-running test frame source: VBLANK / ACTIVE / HBLANK sequencer with shadowed
// geometry, driving a registered pattern generator and sync outputs aligned to it.
module image_stream_source
  import image_pkg::*;
#(
  parameter int unsigned H_BLANK     = 16,
  parameter int unsigned V_BLANK_CYC = 64
) (
  input logic                   clk,
  input logic                   reset_n,
  image_stream_source_if.master stream
);

  localparam logic [15:0] LP_H_LAST = 16'(H_BLANK - 1);
  localparam logic [15:0] LP_V_LAST = 16'(V_BLANK_CYC - 1);

  state_t      r_state,     w_state_nxt;
  logic [10:0] r_x_cnt,     w_x_nxt;
  logic [9:0]  r_y_cnt,     w_y_nxt;
  logic [15:0] r_blank_cnt, w_blank_nxt;
  logic [10:0] r_width,     w_width_nxt;
  logic [9:0]  r_height,    w_height_nxt;
  pattern_t    r_pattern,   w_pattern_nxt;
  logic [7:0]  r_bar_step,  w_bar_step_nxt;
  logic [7:0]  r_bar_px,    w_bar_px_nxt;
  logic [2:0]  r_bar_idx,   w_bar_idx_nxt;

  logic w_start, w_load, w_x_last, w_y_last;
  logic r_frame_clk, r_line_ce, r_sof, r_eol;
  rgb_t w_rgb;

  assign w_start  = stream.enable && (stream.img_width != '0) && (stream.img_height != '0);
  assign w_x_last = (r_x_cnt == r_width - 11'd1);
  assign w_y_last = (r_y_cnt == r_height - 10'd1);

  always_comb begin
    // NOTE: every signal gets its hold value first so no path through the case infers a latch.
    w_state_nxt    = r_state;
    w_x_nxt        = r_x_cnt;
    w_y_nxt        = r_y_cnt;
    w_blank_nxt    = r_blank_cnt;
    w_width_nxt    = r_width;
    w_height_nxt   = r_height;
    w_pattern_nxt  = r_pattern;
    w_bar_step_nxt = r_bar_step;
    w_bar_px_nxt   = r_bar_px;
    w_bar_idx_nxt  = r_bar_idx;
    w_load         = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (w_start) w_load = 1'b1;
      end

      ST_VBLANK: begin
        if (r_blank_cnt == LP_V_LAST) begin
          w_state_nxt   = ST_ACTIVE;
          w_x_nxt       = '0;
          w_y_nxt       = '0;
          w_bar_px_nxt  = '0;
          w_bar_idx_nxt = '0;
        end else begin
          w_blank_nxt = r_blank_cnt + 16'd1;
        end
      end

      ST_ACTIVE: begin
        if (w_x_last) begin
          w_state_nxt = ST_HBLANK;
          w_blank_nxt = '0;
        end else begin
          w_x_nxt = r_x_cnt + 11'd1;
          // Bar index saturates on black so remainder pixels never wrap to white.
          if (r_bar_idx != 3'd7) begin
            if (r_bar_px == r_bar_step - 8'd1) begin
              w_bar_idx_nxt = r_bar_idx + 3'd1;
              w_bar_px_nxt  = '0;
            end else begin
              w_bar_px_nxt = r_bar_px + 8'd1;
            end
          end
        end
      end

      ST_HBLANK: begin
        if (r_blank_cnt == LP_H_LAST) begin
          if (w_y_last) begin
            if (w_start) w_load = 1'b1;
            else         w_state_nxt = ST_IDLE;
          end else begin
            w_state_nxt   = ST_ACTIVE;
            w_y_nxt       = r_y_cnt + 10'd1;
            w_x_nxt       = '0;
            w_bar_px_nxt  = '0;
            w_bar_idx_nxt = '0;
          end
        end else begin
          w_blank_nxt = r_blank_cnt + 16'd1;
        end
      end

      default: w_state_nxt = ST_IDLE;
    endcase

    // Geometry and pattern are captured only here, so mid-frame input changes wait a frame.
    if (w_load) begin
      w_state_nxt    = ST_VBLANK;
      w_blank_nxt    = '0;
      w_width_nxt    = stream.img_width;
      w_height_nxt   = stream.img_height;
      w_pattern_nxt  = pattern_t'(stream.pattern_sel);
      w_bar_step_nxt = (stream.img_width[10:3] == 8'd0) ? 8'd1 : stream.img_width[10:3];
    end
  end

  // NOTE: state and counters use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ST_IDLE;
      r_x_cnt     <= '0;
      r_y_cnt     <= '0;
      r_blank_cnt <= '0;
      r_width     <= '0;
      r_height    <= '0;
      r_pattern   <= PAT_BARS;
      r_bar_step  <= '0;
      r_bar_px    <= '0;
      r_bar_idx   <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_x_cnt     <= w_x_nxt;
      r_y_cnt     <= w_y_nxt;
      r_blank_cnt <= w_blank_nxt;
      r_width     <= w_width_nxt;
      r_height    <= w_height_nxt;
      r_pattern   <= w_pattern_nxt;
      r_bar_step  <= w_bar_step_nxt;
      r_bar_px    <= w_bar_px_nxt;
      r_bar_idx   <= w_bar_idx_nxt;
    end
  end

  // Sync flags take one register stage to line up with the pattern generator output.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_frame_clk <= 1'b0;
      r_line_ce   <= 1'b0;
      r_sof       <= 1'b0;
      r_eol       <= 1'b0;
    end else begin
      r_frame_clk <= (r_state == ST_VBLANK);
      r_line_ce   <= (r_state == ST_ACTIVE);
      r_sof       <= (r_state == ST_ACTIVE) && (r_x_cnt == '0) && (r_y_cnt == '0);
      r_eol       <= (r_state == ST_ACTIVE) && w_x_last;
    end
  end

  image_pattern_lut u_pattern_lut (
    .clk       (clk),
    .reset_n   (reset_n),
    .i_active  (r_state == ST_ACTIVE),
    .i_x       (r_x_cnt[7:0]),
    .i_y       (r_y_cnt[7:0]),
    .i_bar_idx (r_bar_idx),
    .i_pattern (r_pattern),
    .o_rgb     (w_rgb)
  );

  assign stream.frame_clk_o = r_frame_clk;
  assign stream.frame_ce_o  = r_line_ce;
  assign stream.valid_o     = r_line_ce;
  assign stream.img_data_o  = w_rgb;
  assign stream.sof_o       = r_sof;
  assign stream.eol_o       = r_eol;

endmodule
